// File: rtl/ahbsram_slave_if.sv
// ---------------------------------------------------------------------------
// ahbsram_slave_if
// AHB-Lite slave front end that initiates the SRAM control request/ack
// handshake. Each legal AHB transfer becomes one single-cycle ahbsram_req
// pulse. Address, size and direction are held stable until the completing
// data-phase cycle. The AHB data phase then completes when sramahb_ack
// returns. Illegal size/alignment yields a two-cycle AHB ERROR response.
//
// Ports
//   HCLK, HRESETN         clock, synchronous active-low reset
//   HSEL..HREADYIN        AHB-Lite slave inputs (address/control/write data)
//   HREADYOUT, HRESP      AHB-Lite slave response (decoded from state)
//   HRDATA                read data, straight from sramahb_rdata
//   ahbsram_req           one-cycle access request (held off while BUSY)
//   ahbsram_write/size/addr  registered transfer attributes
//   ahbsram_wdata(_usram) write data (live HWDATA in S_REQ, registered after)
//   sramahb_ack, sramahb_rdata  SRAM-side completion and read data
//   BUSY                  SRAM busy, stalls the request in S_REQ
// ---------------------------------------------------------------------------
module ahbsram_slave_if #(
    parameter int unsigned AHB_DWIDTH = 32,
    parameter int unsigned AHB_AWIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  HSEL,
    input  logic [AHB_AWIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [AHB_DWIDTH-1:0] HWDATA,
    input  logic                  HREADYIN,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [AHB_DWIDTH-1:0] HRDATA,
    output logic                  ahbsram_req,
    output logic                  ahbsram_write,
    output logic [2:0]            ahbsram_size,
    output logic [19:0]           ahbsram_addr,
    output logic [AHB_DWIDTH-1:0] ahbsram_wdata,
    output logic [AHB_DWIDTH-1:0] ahbsram_wdata_usram,
    input  logic                  sramahb_ack,
    input  logic [AHB_DWIDTH-1:0] sramahb_rdata,
    input  logic                  BUSY
);

    localparam int unsigned SRAM_AWIDTH = 20;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR1 = 3'd4,
        S_ERR2 = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [SRAM_AWIDTH-1:0] addr_q, addr_d;
    logic [2:0]             size_q, size_d;
    logic                   write_q, write_d;
    logic [AHB_DWIDTH-1:0]  wdata_q, wdata_d;

    logic accept;
    logic legal;

    // Upper address bits and HTRANS[0] carry no information for this slave.
    logic unused_inputs;
    assign unused_inputs = ^{HADDR[AHB_AWIDTH-1:SRAM_AWIDTH], HTRANS[0]};

    // Address-phase qualification and size/alignment legality.
    always_comb begin
        accept = HSEL & HREADYIN & HTRANS[1];
        case (HSIZE)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~HADDR[0];
            3'b010:  legal = (HADDR[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            S_REQ: begin
                // First data-phase cycle: HWDATA is valid and held while stalled.
                wdata_d = HWDATA;
                if (!BUSY) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sramahb_ack) begin
                    state_d = S_DONE;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                // S_IDLE, S_DONE, S_ERR2 (and any stray encoding) can accept.
                if (accept) begin
                    state_d = legal ? S_REQ : S_ERR1;
                    addr_d  = HADDR[SRAM_AWIDTH-1:0];
                    size_d  = HSIZE;
                    write_d = HWRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and attribute registers.
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    // AHB response decoded from state; read data passes straight through.
    assign HREADYOUT = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign HRDATA    = sramahb_rdata;

    // Request fires in S_REQ as soon as the SRAM side is not busy.
    assign ahbsram_req         = (state_q == S_REQ) & ~BUSY;
    assign ahbsram_write       = write_q;
    assign ahbsram_size        = size_q;
    assign ahbsram_addr        = addr_q;
    assign ahbsram_wdata       = (state_q == S_REQ) ? HWDATA : wdata_q;
    assign ahbsram_wdata_usram = ahbsram_wdata;

endmodule

// File: doc/ahbsram_slave_if.md
Name: ahbsram_slave_if

Overview:
- AHB-Lite slave front end that acts as the initiator of the SRAM control request/ack interface.
- Decodes AHB transfers and issues single-cycle ahbsram_req pulses with address, size, write and wdata held stable.
- Waits for sramahb_ack, then completes the AHB data phase with HRDATA taken from sramahb_rdata.
- Sits between the AHB-Lite bus matrix and the SRAM control interface block.

Parameters:
AHB_DWIDTH, 32, data bus width (only 32 supported)
AHB_AWIDTH, 32, HADDR width; only [19:0] forwarded

Ports:
HCLK  in  1  clock
HRESETN  in  1  reset, synchronous, active-low
HSEL  in  1  slave select
HADDR  in  AHB_AWIDTH  address
HTRANS  in  2  transfer type
HWRITE  in  1  write/read
HSIZE  in  3  transfer size
HWDATA  in  AHB_DWIDTH  write data
HREADYIN  in  1  bus ready
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
HRDATA  out  AHB_DWIDTH  read data
ahbsram_req  out  1  one-cycle access request
ahbsram_write  out  1  request is write
ahbsram_size  out  3  registered HSIZE
ahbsram_addr  out  20  registered HADDR[19:0]
ahbsram_wdata  out  AHB_DWIDTH  write data
ahbsram_wdata_usram  out  AHB_DWIDTH  identical copy of ahbsram_wdata
sramahb_ack  in  1  access complete (one-cycle pulse)
sramahb_rdata  in  AHB_DWIDTH  read data, valid the cycle after ack
BUSY  in  1  SRAM busy; request issue is held off while high

Behaviour:
- Reset values, applied on a HCLK edge with HRESETN=0:
  - state=S_IDLE, HREADYOUT=1, HRESP=0, ahbsram_req=0.
  - addr, size, write and wdata registers = 0.
  - A reset mid-transfer abandons the transfer; no further req is issued.
- Address phase accepted when HSEL & HREADYIN & HTRANS[1] in S_IDLE or S_DONE.
  - On accept, register HADDR[19:0], HSIZE and HWRITE.
- Legal transfer: HSIZE<=3'b010 and aligned (halfword: HADDR[0]=0; word: HADDR[1:0]=0). Legal -> S_REQ; otherwise -> S_ERR1.
- HTRANS IDLE/BUSY, or HSEL=0: zero-wait OKAY, no req, state -> S_IDLE (unless accepting).
- States (HREADYOUT is decoded from state):
  - S_IDLE: HREADYOUT=1, HRESP=0.
  - S_REQ: HREADYOUT=0.
    - BUSY=0: ahbsram_req=1 for this cycle only, -> S_WAIT.
    - BUSY=1: req=0, stay in S_REQ.
    - Write data: this is the first data-phase cycle; wdata_reg captures HWDATA, and ahbsram_wdata = HWDATA here, wdata_reg in every other state.
  - S_WAIT: HREADYOUT=0, req=0. On sramahb_ack=1 -> S_DONE; otherwise stay.
  - S_DONE: HREADYOUT=1, HRESP=0, HRDATA=sramahb_rdata. Next state: S_REQ or S_ERR1 if a new transfer is accepted, else S_IDLE.
  - S_ERR1: HREADYOUT=0, HRESP=1, no req, -> S_ERR2.
  - S_ERR2: HREADYOUT=1, HRESP=1. Next state: same rules as S_DONE.
- Latency: address phase at cycle 0, req at cycle 1 (BUSY=0), ack at cycle 2, HREADYOUT=1 at cycle 3. That is 2 wait states for both read and write, plus 1 per cycle of BUSY.
- ahbsram_addr, ahbsram_size and ahbsram_write stay stable from S_REQ until S_DONE is exited. ahbsram_wdata is stable from S_WAIT onward.
- HRDATA = sramahb_rdata in all states; it is only meaningful in S_DONE of a read.
- sramahb_ack while in S_IDLE, S_REQ, S_DONE or S_ERR*: ignored.
- Back-to-back: a transfer accepted in S_DONE issues its req on the following cycle.
- HRESP=0 in every state except S_ERR1 and S_ERR2.

Test Plan:
- Word write: HADDR=0x00000104, HSIZE=010, HWDATA=0xDEADBEEF.
  - Response: req pulse at cycle 1 with addr=0x00104, write=1, wdata=0xDEADBEEF.
  - Ack at cycle 2; HREADYOUT low for 2 cycles; HRESP=0.
- Word read: HADDR=0x104; model returns 0xDEADBEEF the cycle after ack.
  - Response: HRDATA=0xDEADBEEF with HREADYOUT=1 at cycle 3.
- Misaligned halfword: HADDR=0x101, HSIZE=001.
  - Response: no req; HRESP=1 for 2 cycles, HREADYOUT=0 then 1.
- HSIZE=011: same two-cycle ERROR response, no req.
- BUSY held high 3 cycles during S_REQ.
  - Response: req=0 for those 3 cycles, then a single req pulse; HREADYOUT low for 5 cycles total.
- Back-to-back: write to 0x10 followed immediately by read of 0x10.
  - Response: second req issued the cycle after the first HREADYOUT=1; read returns the written data.
- Reset asserted in S_WAIT: next cycle HREADYOUT=1, req=0, state S_IDLE; a late ack is ignored.
